echo_request_dispatch: RTL and testbench
========================================

# echo_request_dispatch

Parametrised, buffered tag demultiplexer between the indication/request pipe and a bank of request methods. Accepts tagged messages on `pipe$enq`, stores them in an internal FIFO, and dispatches the head entry to the one method selected by its tag, waiting for that method's RDY. Unknown tags are dropped and counted rather than silently discarded. It is the generalised successor of the fixed two-method request input stage: N methods, configurable depth, decoupled input ready.

## Interface
- NUM_METHODS, 2, number of request methods (1..15); tag k (1..NUM_METHODS) selects method k-1
- TAG_WIDTH, 32, width of tag field at pipe$enq$v[TAG_WIDTH-1:0]
- PAYLOAD_WIDTH, 64, payload at pipe$enq$v[TAG_WIDTH+PAYLOAD_WIDTH-1:TAG_WIDTH] (meth in low 32 bits, v in next 32 bits when 64)
- DEPTH, 4, FIFO entries; power of two, >= 2
- CLK  in  1  clock; all state on rising edge
- RST  in  1  synchronous, active-high reset
- pipe$enq__ENA  in  1  message valid/enqueue
- pipe$enq$v  in  TAG_WIDTH+PAYLOAD_WIDTH  tagged message
- pipe$enq__RDY  out  1  FIFO not full (registered)
- request$__ENA  out  NUM_METHODS  one-hot dispatch strobe
- request$payload  out  PAYLOAD_WIDTH  head payload, broadcast to all methods
- request$__RDY  in  NUM_METHODS  per-method ready
- occupancy  out  log2(DEPTH)+1  entries held
- bad_tag__ENA  out  1  pulses the cycle an unknown-tag entry is dropped
- bad_tag_count  out  16  saturating count of dropped entries

## Operation
- Enqueue when pipe$enq__ENA & pipe$enq__RDY; ENA while RDY low is ignored (no write, no error).
- Head decode: idx = tag-1 when 1 <= tag <= NUM_METHODS, else bad. Tag compare is over full TAG_WIDTH (tag 0x1_0000_0001 is bad).
- Valid tag: request$__ENA[idx] = !empty & request$__RDY[idx]; dequeue same cycle. At most one ENA bit high; no other bit depends on other RDYs (unlike the old fixed stage, which ANDed all RDYs).
- Bad tag: dropped on the cycle it reaches head regardless of any RDY; bad_tag__ENA=1, counter += 1, saturates at 0xFFFF; no request ENA.
- Strict in-order: head blocks later entries (head-of-line), including entries for other methods.
- request$payload driven from head whenever !empty; don't-care (hold head storage) when empty.
- Reset: pointers, occupancy, bad_tag_count clear to 0; pipe$enq__RDY=1 in the cycle after RST; request$__ENA=0 and bad_tag__ENA=0 during and after reset until an entry is enqueued. Reset mid-transfer discards all stored entries; an ENA coincident with RST is lost.

## Timing
- Latency: message enqueued at edge t is at head in cycle t+1; earliest ENA in cycle t+1 (one-cycle cut-through-free).
- Dispatch/drop is combinational from head state and request$__RDY; FIFO update on next edge.
- pipe$enq__RDY is registered from occupancy: = (occupancy < DEPTH); a same-cycle dequeue on a full FIFO does not raise RDY until next cycle (no combinational RDY path in->out).
- Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance.
- Pointer wrap: log2(DEPTH)+1-bit pointers; full = MSBs differ, low bits equal; empty = equal.
- Throughput: one message per cycle sustained when destination RDY held high.

## Structure
- Shared package echo_dispatch_pkg: tag-decode function (tag -> {bad, idx}), counter width constant, message field-offset localparams.
- One sub-module: dispatch_fifo (DEPTH x (TAG_WIDTH+PAYLOAD_WIDTH), registered full/empty, occupancy); top holds decode, one-hot ENA, bad-tag counter.

## Test plan
- Reset then single enq tag=1, payload meth=0x5, v=0xAA, all RDY=1 -> request$__ENA=01 in cycle t+1, payload {0xAA,0x5}, occupancy back to 0.
- Fill: RDY=00, 5 enqs with DEPTH=4 -> first 4 accepted, pipe$enq__RDY=0 after 4th, 5th ignored, occupancy=4; raise RDY=11 -> 4 ENAs on consecutive cycles in order.
- Head-of-line: queue tag2 then tag1, RDY=01 -> no ENA; raise RDY[1] -> ENA=10 then ENA=01.
- Bad tags 0, 3, 0x100000001 -> three bad_tag__ENA pulses, bad_tag_count=3, no request ENA, with RDY=00 throughout.
- Counter saturation: 65537 bad tags -> bad_tag_count=0xFFFF.
- RST asserted with occupancy=3 -> next cycle occupancy=0, ENA=0, pipe$enq__RDY=1, bad_tag_count=0.

Source files
------------

// File: rtl/echo_dispatch_pkg.sv
// Shared definitions for the tagged request dispatcher: message layout,
// bad-tag counter width and the tag-to-method decode.
package echo_dispatch_pkg;

    localparam int TAG_MAX   = 64;  // widest tag the decoder accepts
    localparam int IDX_WIDTH = 4;   // enough for 15 methods
    localparam int CNT_WIDTH = 16;
    localparam int TAG_LSB   = 0;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = 16'hFFFF;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 16'h0001;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = 4'd1;

    typedef struct packed {
        logic                 bad;
        logic [IDX_WIDTH-1:0] idx;
    } tag_dec_t;

    // Tag k in 1..num_methods selects method k-1; anything else, including
    // values with upper bits set, is bad.
    function automatic tag_dec_t decode_tag(input logic [TAG_MAX-1:0]   tag,
                                            input logic [IDX_WIDTH-1:0] num_methods);
        tag_dec_t d;
        if ((tag != {TAG_MAX{1'b0}}) &&
            (tag <= {{(TAG_MAX-IDX_WIDTH){1'b0}}, num_methods})) begin
            d.bad = 1'b0;
            d.idx = tag[IDX_WIDTH-1:0] - IDX_ONE;
        end else begin
            d.bad = 1'b1;
            d.idx = {IDX_WIDTH{1'b0}};
        end
        return d;
    endfunction

endpackage

// File: rtl/echo_request_dispatch_fifo.sv
// Message FIFO for the dispatcher: wrap-bit pointers, registered full/empty
// flags and occupancy so that the input ready has no combinational path.
module dispatch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r, rd_ptr_r, occ_r;
    logic [AW:0]      wr_ptr_s, rd_ptr_s, occ_s;
    logic             full_r, empty_r, full_s, empty_s;
    logic             do_push_s, do_pop_s;

    // Next pointers and flags, derived from the advanced pointers
    always_comb begin
        do_push_s = push & ~full_r;
        do_pop_s  = pop & ~empty_r;
        if (do_push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        occ_s   = wr_ptr_s - rd_ptr_s;
        empty_s = (wr_ptr_s == rd_ptr_s);
        full_s  = (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                  (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            occ_r    <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            occ_r    <= occ_s;
            full_r   <= full_s;
            empty_r  <= empty_s;
        end
    end

    // Storage write; contents are not cleared, the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r[AW-1:0]];
    assign full      = full_r;
    assign empty     = empty_r;
    assign occupancy = occ_r;

endmodule

// File: rtl/echo_request_dispatch.sv
// Buffered tag demultiplexer: queues tagged messages and hands the head entry
// to the method its tag selects, dropping and counting unknown tags.
module echo_request_dispatch
    import echo_dispatch_pkg::*;
#(
    parameter int NUM_METHODS   = 2,
    parameter int TAG_WIDTH     = 32,  // at most TAG_MAX
    parameter int PAYLOAD_WIDTH = 64,
    parameter int DEPTH         = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               pipe_enq__ENA,
    input  logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] pipe_enq_v,
    output logic                               pipe_enq__RDY,
    output logic [NUM_METHODS-1:0]             request__ENA,
    output logic [PAYLOAD_WIDTH-1:0]           request_payload,
    input  logic [NUM_METHODS-1:0]             request__RDY,
    output logic [$clog2(DEPTH):0]             occupancy,
    output logic                               bad_tag__ENA,
    output logic [CNT_WIDTH-1:0]               bad_tag_count
);

    localparam int MSG_WIDTH   = TAG_WIDTH + PAYLOAD_WIDTH;
    localparam int PAYLOAD_LSB = TAG_LSB + TAG_WIDTH;
    localparam logic [IDX_WIDTH-1:0] NUM_M = IDX_WIDTH'(NUM_METHODS);

    logic [MSG_WIDTH-1:0]   head_s;
    logic [TAG_MAX-1:0]     head_tag_ext_s;
    tag_dec_t               dec_s;
    logic                   full_s, empty_s, live_s, bad_s, pop_s;
    logic [NUM_METHODS-1:0] ena_s;
    logic [CNT_WIDTH-1:0]   bad_count_r;

    dispatch_fifo #(
        .WIDTH (MSG_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (pipe_enq__ENA),
        .push_data (pipe_enq_v),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .occupancy (occupancy)
    );

    // Head decode and dispatch; each ENA bit looks only at its own RDY
    always_comb begin
        head_tag_ext_s = {TAG_MAX{1'b0}};
        head_tag_ext_s[TAG_WIDTH-1:0] = head_s[TAG_LSB +: TAG_WIDTH];
        dec_s  = decode_tag(head_tag_ext_s, NUM_M);
        live_s = ~empty_s & ~RST;
        ena_s  = {NUM_METHODS{1'b0}};
        for (int k = 0; k < NUM_METHODS; k++) begin
            ena_s[k] = live_s & ~dec_s.bad & (dec_s.idx == IDX_WIDTH'(k)) &
                       request__RDY[k];
        end
        bad_s = live_s & dec_s.bad;
        pop_s = bad_s | (|ena_s);
    end

    // Saturating count of dropped entries
    always_ff @(posedge CLK) begin
        if (RST) begin
            bad_count_r <= {CNT_WIDTH{1'b0}};
        end else if (bad_s && (bad_count_r != CNT_MAX)) begin
            bad_count_r <= bad_count_r + CNT_ONE;
        end else begin
            bad_count_r <= bad_count_r;
        end
    end

    assign pipe_enq__RDY   = ~full_s;
    assign request__ENA    = ena_s;
    assign request_payload = head_s[PAYLOAD_LSB +: PAYLOAD_WIDTH];
    assign bad_tag__ENA    = bad_s;
    assign bad_tag_count   = bad_count_r;

endmodule

// File: tb/tb_echo_request_dispatch.sv
// Randomised scoreboard bench for echo_request_dispatch: accepted messages are
// queued with the cycle they reach the head; a monitor pops and checks dispatches.
module tb_echo_request_dispatch;

    localparam int NM    = 2;
    localparam int TW    = 40;
    localparam int PW    = 64;
    localparam int DEPTH = 4;
    localparam int MW    = TW + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_ena;
    logic [MW-1:0] enq_v;
    logic          enq_rdy;
    logic [NM-1:0] req_ena;
    logic [PW-1:0] payload;
    logic [NM-1:0] req_rdy;
    logic [2:0]    occ;
    logic          bad_ena;
    logic [15:0]   bad_cnt;

    always #5 clk = ~clk;

    echo_request_dispatch #(
        .NUM_METHODS   (NM),
        .TAG_WIDTH     (TW),
        .PAYLOAD_WIDTH (PW),
        .DEPTH         (DEPTH)
    ) dut (
        .CLK             (clk),
        .RST             (rst),
        .pipe_enq__ENA   (enq_ena),
        .pipe_enq_v      (enq_v),
        .pipe_enq__RDY   (enq_rdy),
        .request__ENA    (req_ena),
        .request_payload (payload),
        .request__RDY    (req_rdy),
        .occupancy       (occ),
        .bad_tag__ENA    (bad_ena),
        .bad_tag_count   (bad_cnt)
    );

    typedef struct {
        bit            bad;
        int            idx;
        logic [PW-1:0] pl;
        int            avail;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   model_cnt = 0;
    bit   model_ok  = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [TW-1:0] tag, input logic [PW-1:0] pl, input int avail);
        exp_t e;
        logic [63:0] t;
        t       = 64'(tag);
        e.bad   = !((t >= 64'd1) && (t <= 64'(NM)));
        e.idx   = e.bad ? 0 : int'(t) - 1;
        e.pl    = pl;
        e.avail = avail;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drive one cycle; a message is expected to be taken when the model FIFO has room
    task automatic step(input bit ena, input logic [TW-1:0] tag, input logic [PW-1:0] pl,
                        input logic [NM-1:0] rdy);
        enq_ena = ena;
        enq_v   = {pl, tag};
        req_rdy = rdy;
        if (ena && !rst && (sb.size() < DEPTH)) sb.push_back(mk(tag, pl, cyc + 1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] rand_tag();
        case ($urandom_range(0, 7))
            0:       return 40'd0;
            1, 2:    return 40'd1;
            3, 4:    return 40'd2;
            5:       return 40'd3;
            6:       return 40'h01_0000_0001;
            default: return {8'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Monitor: compare what the DUT presents against the scoreboard head
    initial begin
        int   nvis;
        bit   fire;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ena_in_reset", 64'(req_ena), 64'd0);
                chk("bad_in_reset", 64'(bad_ena), 64'd0);
                sb.delete();
                model_cnt = 0;
                model_ok  = 1'b1;
            end else if (model_ok) begin
                nvis = 0;
                foreach (sb[i]) if (sb[i].avail <= cyc) nvis++;
                chk("occupancy", 64'(occ), 64'(nvis));
                chk("enq_rdy", 64'(enq_rdy), 64'(nvis < DEPTH));
                chk("bad_count", 64'(bad_cnt), 64'(model_cnt));
                fire = (nvis > 0) && (sb[0].bad || (((req_rdy >> sb[0].idx) & 2'b01) != 2'b00));
                if (fire) begin
                    e = sb.pop_front();
                    chk("bad_ena", 64'(bad_ena), 64'(e.bad));
                    if (e.bad) begin
                        chk("ena_on_drop", 64'(req_ena), 64'd0);
                        if (model_cnt < 65535) model_cnt++;
                    end else begin
                        chk("req_ena", 64'(req_ena), 64'(NM'(1) << e.idx));
                        chk("payload", payload, e.pl);
                    end
                end else begin
                    chk("idle_ena", 64'(req_ena), 64'd0);
                    chk("idle_bad", 64'(bad_ena), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; enq_ena = 1'b0; enq_v = '0; req_rdy = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 40'd0, 64'd0, 2'b00);

        // single message, all methods ready
        step(1'b1, 40'd1, {32'hAA, 32'h5}, 2'b11);
        repeat (3) step(1'b0, 40'd0, 64'd0, 2'b11);

        // fill with nothing ready; fifth offer must be ignored
        for (int i = 0; i < 5; i++) step(1'b1, 40'(i % 2 + 1), {32'($urandom), 32'(i)}, 2'b00);
        repeat (2) step(1'b0, 40'd0, 64'd0, 2'b00);
        repeat (6) step(1'b0, 40'd0, 64'd0, 2'b11);

        // head-of-line blocking
        step(1'b1, 40'd2, 64'h2222, 2'b01);
        step(1'b1, 40'd1, 64'h1111, 2'b01);
        repeat (3) step(1'b0, 40'd0, 64'd0, 2'b01);
        repeat (3) step(1'b0, 40'd0, 64'd0, 2'b11);

        // unknown tags dropped with nothing ready
        step(1'b1, 40'd0, 64'd10, 2'b00);
        step(1'b1, 40'd3, 64'd11, 2'b00);
        step(1'b1, 40'h01_0000_0001, 64'd12, 2'b00);
        repeat (3) step(1'b0, 40'd0, 64'd0, 2'b00);
        chk("bad_count_three", 64'(bad_cnt), 64'd3);

        // reset with three entries held; coincident offer is lost
        for (int i = 0; i < 3; i++) step(1'b1, 40'd1, 64'(i), 2'b00);
        step(1'b0, 40'd0, 64'd0, 2'b00);
        chk("occ_before_reset", 64'(occ), 64'd3);
        rst = 1'b1;
        step(1'b1, 40'd2, 64'd99, 2'b00);
        rst = 1'b0;
        chk("occ_after_reset", 64'(occ), 64'd0);
        chk("rdy_after_reset", 64'(enq_rdy), 64'd1);
        chk("cnt_after_reset", 64'(bad_cnt), 64'd0);
        repeat (2) step(1'b0, 40'd0, 64'd0, 2'b11);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            step(($urandom_range(0, 3) != 0), rand_tag(), {32'($urandom), 32'($urandom)}, NM'($urandom));
        end
        rst = 1'b0;
        repeat (8) step(1'b0, 40'd0, 64'd0, 2'b11);

        // counter saturation
        rst = 1'b1;
        step(1'b0, 40'd0, 64'd0, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 65537; i++)
            step(1'b1, (i % 2 == 0) ? 40'd0 : 40'h01_0000_0002, 64'(i), NM'($urandom));
        repeat (3) step(1'b0, 40'd0, 64'd0, 2'b00);
        chk("bad_count_saturated", 64'(bad_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
